acondicionador_entrada: RTL and testbench
=========================================

# acondicionador_entrada

Input conditioning stage that sits directly upstream of the next-state logic of the lab state machine. It takes the raw board switch that drives the FSM input `x` and the raw step pushbutton, and processes each one in three steps: synchronise, debounce, and (for the button) reduce to a one-cycle step pulse. It delivers a clean `x` level plus a `paso` enable for the 3-bit state register. Every output is a registered, glitch-free signal in the `clk` domain.

## Interface
- `N_ANTIRREBOTE`, default 16: consecutive synchronised samples a new level must hold before it is accepted; legal range ≥ 1.
- `ANCHO_CNT`, default `$clog2(N_ANTIRREBOTE+1)`: debounce counter width. Derived; not overridden.

- `clk` input, 1 bit: the only clock; all state updates on its rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `sw_x` input, 1 bit: raw switch, asynchronous to `clk`, may bounce.
- `btn_paso` input, 1 bit: raw pushbutton, asynchronous, active-high, may bounce.
- `x` output, 1 bit: debounced switch level, fed to the next-state logic.
- `paso` output, 1 bit: one-cycle pulse per accepted button press; state-register enable.
- `estable` output, 1 bit: 1 when both channels are in state ESTABLE.

## Operation
- Two identical channels, one for `sw_x` and one for `btn_paso`. Each channel has the following parts:
  - 2-FF synchroniser `s1` → `s2`.
  - Accepted level `q`.
  - Counter `cnt`.
  - FSM with two states, ESTABLE and CONTANDO.
- ESTABLE:
  - If `s2 == q`: stay; `cnt` = 0.
  - If `s2 != q`: go to CONTANDO, `cnt` ← 1. When N = 1, instead update `q` ← `s2` immediately and stay in ESTABLE.
- CONTANDO:
  - If `s2 == q`: the change was a bounce. Go to ESTABLE, `cnt` ← 0; `q` unchanged.
  - If `s2 != q` and `cnt == N-1`: `q` ← `s2`, `cnt` ← 0, go to ESTABLE.
  - Otherwise: `cnt` ← `cnt+1`.
- `q` therefore changes only after N consecutive differing `s2` samples. `cnt` never exceeds N-1, so there is no wrap.
- `x` = `q` of the switch channel.
- `paso` is registered and equals `q_btn & ~q_btn_d`, where `q_btn_d` is `q_btn` delayed one cycle.
  - A held button yields exactly one pulse.
  - The release, bouncing or not, yields none.
- Channels are independent. If both `q` values change on the same edge, `x` is updated one cycle before `paso` asserts, so the state register always samples the new `x` together with the step.
- `estable` = (switch FSM == ESTABLE) & (button FSM == ESTABLE).

## Timing
- Reset values, held while `rst` = 1:
  - `s1`, `s2`, `q`, `q_btn_d`, `cnt`: all 0.
  - Both FSMs: ESTABLE.
  - Outputs: `x` = 0, `paso` = 0, `estable` = 1.
- Latency: a raw edge captured by `s1` at edge k gives `s2` at edge k+1, and `q`/`x` at edge k+1+N.
- `paso` is high only during the cycle following edge k+2+N.
- For raw-capture edge k, `estable` is 0 from edge k+2 to edge k+1+N.
- Reset mid-count discards all progress. A level still held after reset is debounced from scratch, with `s1` capturing on the first edge after reset release.
- `rst` has priority over all other updates on the same edge.

## Structure
- Package `acondicionador_pkg` contains:
  - `typedef enum logic {ESTABLE, CONTANDO} estado_antirrebote_t`
  - `localparam int N_ANTIRREBOTE_DEF = 16`
- Sub-module `antirrebote`, instantiated twice.
  - Contents: synchroniser, FSM and counter.
  - Parameter: `N_ANTIRREBOTE`.
  - Ports: `clk`, `rst`, `entrada`, `nivel`, `contando`.
- The top level adds the `paso` edge detector and the `estable` AND.

## Test plan
All scenarios use N_ANTIRREBOTE = 4.
- Reset: `rst` = 1 for 2 cycles with both raw inputs 0 → `x` = 0, `paso` = 0, `estable` = 1.
- Clean switch: `sw_x` 0→1, captured by `s1` at edge 10 → `x` = 1 at edge 15; `estable` = 0 from edge 12 to edge 15.
- Glitch: `sw_x` high for 3 cycles, then low → `x` stays 0, `estable` returns to 1, no `paso`.
- Bouncy press: `btn_paso` toggles every cycle for 5 cycles, then holds high 30 cycles, then bounces low → exactly one `paso` pulse, 1 cycle wide, and no pulse on release.
- Simultaneous: `sw_x` and `btn_paso` rise on the same cycle → `x` = 1 one cycle before `paso` = 1.
- Reset mid-count: `rst` asserted while the switch FSM is in CONTANDO with `cnt` = 2, `sw_x` held at 1 → `x` = 0. With the first post-release capture at edge r, `x` = 1 at edge r+5.

Source files
------------

// File: rtl/acondicionador_pkg.sv
// Shared types and defaults for the input conditioning stage of the lab FSM.
// Holds the debounce FSM state encoding and the default acceptance length.
package acondicionador_pkg;

  typedef enum logic {
    ESTABLE  = 1'b0,
    CONTANDO = 1'b1
  } estado_antirrebote_t;

  localparam int N_ANTIRREBOTE_DEF = 16;

endpackage

// File: rtl/antirrebote.sv
// One conditioning channel: 2-FF synchroniser, then an N-sample debounce FSM.
// Latency: raw edge captured at k gives nivel at k+1+N; no backpressure.
module antirrebote
  import acondicionador_pkg::*;
#(
  parameter int N_ANTIRREBOTE = N_ANTIRREBOTE_DEF,
  parameter int ANCHO_CNT     = $clog2(N_ANTIRREBOTE + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic entrada,
  output logic nivel,
  output logic contando
);

  localparam logic [ANCHO_CNT-1:0] CNT_FIN = ANCHO_CNT'(N_ANTIRREBOTE - 1);
  localparam logic [ANCHO_CNT-1:0] CNT_UNO = ANCHO_CNT'(1);

  logic                 s1;
  logic                 s2;
  logic                 q;
  logic                 q_sig;
  logic [ANCHO_CNT-1:0] cnt;
  logic [ANCHO_CNT-1:0] cnt_sig;
  estado_antirrebote_t  estado;
  estado_antirrebote_t  estado_sig;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      q      <= 1'b0;
      cnt    <= '0;
      estado <= ESTABLE;
    end else begin
      s1     <= entrada;
      s2     <= s1;
      q      <= q_sig;
      cnt    <= cnt_sig;
      estado <= estado_sig;
    end
  end

  always_comb begin
    estado_sig = estado;
    q_sig      = q;
    cnt_sig    = cnt;
    case (estado)
      ESTABLE: begin
        cnt_sig = '0;
        if (s2 != q) begin
          // A single-sample window accepts the new level without counting.
          if (N_ANTIRREBOTE == 1) begin
            q_sig = s2;
          end else begin
            estado_sig = CONTANDO;
            cnt_sig    = CNT_UNO;
          end
        end
      end
      CONTANDO: begin
        if (s2 == q) begin
          estado_sig = ESTABLE;
          cnt_sig    = '0;
        end else if (cnt == CNT_FIN) begin
          q_sig      = s2;
          cnt_sig    = '0;
          estado_sig = ESTABLE;
        end else begin
          cnt_sig = cnt + CNT_UNO;
        end
      end
    endcase
  end

  assign nivel    = q;
  assign contando = (estado == CONTANDO);

endmodule

// File: rtl/acondicionador_entrada.sv
// Conditions the raw x switch and step button for the lab FSM: clean x level plus one-cycle paso.
// Latency: x at capture+1+N, paso one cycle after that; no backpressure, outputs are free-running.
module acondicionador_entrada
  import acondicionador_pkg::*;
#(
  parameter int N_ANTIRREBOTE = N_ANTIRREBOTE_DEF,
  parameter int ANCHO_CNT     = $clog2(N_ANTIRREBOTE + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_x,
  input  logic btn_paso,
  output logic x,
  output logic paso,
  output logic estable
);

  logic q_sw;
  logic q_btn;
  logic q_btn_d;
  logic paso_r;
  logic contando_sw;
  logic contando_btn;

  antirrebote #(
    .N_ANTIRREBOTE (N_ANTIRREBOTE),
    .ANCHO_CNT     (ANCHO_CNT)
  ) u_canal_sw (
    .clk      (clk),
    .rst      (rst),
    .entrada  (sw_x),
    .nivel    (q_sw),
    .contando (contando_sw)
  );

  antirrebote #(
    .N_ANTIRREBOTE (N_ANTIRREBOTE),
    .ANCHO_CNT     (ANCHO_CNT)
  ) u_canal_btn (
    .clk      (clk),
    .rst      (rst),
    .entrada  (btn_paso),
    .nivel    (q_btn),
    .contando (contando_btn)
  );

  // Registering the edge puts paso one cycle behind x, so a simultaneous
  // change presents the new x to the state register together with the step.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_btn_d <= 1'b0;
      paso_r  <= 1'b0;
    end else begin
      q_btn_d <= q_btn;
      paso_r  <= q_btn & ~q_btn_d;
    end
  end

  assign x       = q_sw;
  assign paso    = paso_r;
  assign estable = ~contando_sw & ~contando_btn;

endmodule

// File: tb/tb_acondicionador_entrada.sv
// Bench for acondicionador_entrada: directed scenarios plus random bouncing inputs,
// scored cycle by cycle against a run-length model of the debounce rules.
module tb_acondicionador_entrada;

  localparam int N = 4;

  logic clk      = 1'b0;
  logic rst      = 1'b1;
  logic sw_x     = 1'b0;
  logic btn_paso = 1'b0;
  logic x;
  logic paso;
  logic estable;

  acondicionador_entrada #(.N_ANTIRREBOTE(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .sw_x     (sw_x),
    .btn_paso (btn_paso),
    .x        (x),
    .paso     (paso),
    .estable  (estable)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ciclo_n = 0;

  logic [2:0] cola[$];
  logic [2:0] esp_m;

  // Reference: raw -> two-stage delay -> level flips after N consecutive
  // samples differing from the accepted level; the streak restarts on any match.
  logic m_s1[2];
  logic m_s2[2];
  logic m_q[2];
  int   m_racha[2];
  logic m_qd;
  logic m_paso;

  task automatic chequear(input string nombre, input int actual, input int esperado);
    checks++;
    if (actual != esperado) begin
      errors++;
      $display("FAIL %s: obtenido=%0d esperado=%0d", nombre, actual, esperado);
    end
  endtask

  task automatic modelo(input logic r, input logic [1:0] crudo);
    if (r) begin
      for (int i = 0; i < 2; i++) begin
        m_s1[i] = 1'b0; m_s2[i] = 1'b0; m_q[i] = 1'b0; m_racha[i] = 0;
      end
      m_qd   = 1'b0;
      m_paso = 1'b0;
    end else begin
      m_paso = m_q[1] & ~m_qd;
      m_qd   = m_q[1];
      for (int i = 0; i < 2; i++) begin
        if (m_s2[i] != m_q[i]) m_racha[i]++;
        else m_racha[i] = 0;
        if (m_racha[i] == N) begin
          m_q[i]     = m_s2[i];
          m_racha[i] = 0;
        end
        m_s2[i] = m_s1[i];
        m_s1[i] = crudo[i];
      end
    end
    cola.push_back({m_q[0], m_paso, (m_racha[0] == 0 && m_racha[1] == 0)});
  endtask

  task automatic ciclo(input logic r, input logic s, input logic b);
    rst      = r;
    sw_x     = s;
    btn_paso = b;
    @(posedge clk);
    modelo(r, {b, s});
    ciclo_n++;
    @(negedge clk);
    #1;
  endtask

  initial begin
    int lat;
    int n_bajo;
    int n_x;
    int n_paso;
    int ix;
    int ip;
    logic nivel_sw;
    logic nivel_btn;
    logic rst_v;

    fork
      forever begin
        @(negedge clk);
        if (cola.size() > 0) begin
          esp_m = cola.pop_front();
          checks++;
          if ({x, paso, estable} !== esp_m) begin
            errors++;
            $display("FAIL salidas ciclo %0d: x,paso,estable dut=%b esperado=%b",
                     ciclo_n, {x, paso, estable}, esp_m);
          end
        end
      end
    join_none

    // Reset, then idle.
    ciclo(1'b1, 1'b0, 1'b0);
    ciclo(1'b1, 1'b0, 1'b0);
    chequear("reset_estable", int'(estable), 1);
    repeat (8) ciclo(1'b0, 1'b0, 1'b0);

    // Clean switch rise: the first call is the capture edge.
    ciclo(1'b0, 1'b1, 1'b0);
    lat = -1;
    n_bajo = 0;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      ciclo(1'b0, 1'b1, 1'b0);
      if (!estable) n_bajo++;
      if (x) lat = i;
    end
    chequear("latencia_x", lat, N + 1);
    chequear("ciclos_no_estable", n_bajo, N - 1);

    // Back to 0, then a 3-cycle glitch.
    repeat (10) ciclo(1'b0, 1'b0, 1'b0);
    chequear("x_vuelve_0", int'(x), 0);
    n_x = 0;
    n_paso = 0;
    repeat (3) begin
      ciclo(1'b0, 1'b1, 1'b0);
      n_x += int'(x); n_paso += int'(paso);
    end
    repeat (12) begin
      ciclo(1'b0, 1'b0, 1'b0);
      n_x += int'(x); n_paso += int'(paso);
    end
    chequear("glitch_x", n_x, 0);
    chequear("glitch_paso", n_paso, 0);
    chequear("glitch_estable", int'(estable), 1);

    // Bouncy press, long hold, bouncy release.
    n_paso = 0;
    lat = 0;
    for (int i = 0; i < 5; i++) begin
      ciclo(1'b0, 1'b0, (i % 2) == 0);
      n_paso += int'(paso);
    end
    repeat (30) begin
      ciclo(1'b0, 1'b0, 1'b1);
      n_paso += int'(paso);
    end
    chequear("pulsos_pulsacion", n_paso, 1);
    n_paso = 0;
    for (int i = 0; i < 20; i++) begin
      ciclo(1'b0, 1'b0, (i < 5) && (i % 2) == 1);
      n_paso += int'(paso);
    end
    chequear("pulsos_suelta", n_paso, 0);

    // Both inputs rise together.
    ix = -1;
    ip = -1;
    ciclo(1'b0, 1'b1, 1'b1);
    for (int i = 1; i <= 15; i++) begin
      ciclo(1'b0, 1'b1, 1'b1);
      if (x && ix < 0) ix = i;
      if (paso && ip < 0) ip = i;
    end
    chequear("simul_latencia_x", ix, N + 1);
    chequear("simul_x_antes_paso", ip - ix, 1);
    repeat (15) ciclo(1'b0, 1'b0, 1'b0);

    // Reset while the switch channel has counted two samples.
    repeat (4) ciclo(1'b0, 1'b1, 1'b0);
    ciclo(1'b1, 1'b1, 1'b0);
    ciclo(1'b1, 1'b1, 1'b0);
    chequear("reset_medio_x", int'(x), 0);
    ciclo(1'b0, 1'b1, 1'b0);
    lat = -1;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      ciclo(1'b0, 1'b1, 1'b0);
      if (x) lat = i;
    end
    chequear("reset_medio_latencia", lat, N + 1);

    // Random bouncing inputs with occasional resets.
    nivel_sw  = 1'b1;
    nivel_btn = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(7) == 0) nivel_sw = ~nivel_sw;
      if ($urandom_range(9) == 0) nivel_btn = ~nivel_btn;
      rst_v = ($urandom_range(149) == 0);
      ciclo(rst_v, nivel_sw, nivel_btn);
    end

    repeat (2) @(negedge clk);
    chequear("cola_vacia", cola.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
